// File: rtl/core_loader.sv
// core_loader: host command sequencer that loads a core's instruction/data memories and drives its reset/run.
module core_loader #(
    parameter int CORE_RST_CYCLES = 4,
    parameter int ADDR_STEP       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] insn_addr,
    output logic [31:0] insn_din,
    output logic        insn_we,
    output logic [31:0] data_addr,
    output logic [31:0] data_din,
    output logic        data_we,
    output logic        core_reset,
    output logic        run,
    output logic        busy,
    output logic        err,
    output logic [31:0] run_cycles
);
    typedef enum logic [2:0] {IDLE, ADDR, PAYLOAD, CRST, RUNNING} state_t;

    state_t      state_q, state_d;
    logic        tgt_q, tgt_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] crst_q, crst_d;
    logic        run_q, run_d;
    logic        err_q, err_d;
    logic [31:0] rc_q, rc_d;
    logic [31:0] insn_addr_q, insn_addr_d, insn_din_q, insn_din_d;
    logic [31:0] data_addr_q, data_addr_d, data_din_q, data_din_d;
    logic        insn_we_q, insn_we_d, data_we_q, data_we_d;
    logic        busy_q, busy_d, core_reset_q, core_reset_d;
    logic        acc;
    logic [3:0]  op;
    logic        unused_bits;

    assign unused_bits = ^s_data[27:16];
    // s_ready is gated by reset so it reads 0 while reset is held
    assign s_ready = reset && state_q != CRST;
    assign acc     = s_valid && s_ready;
    assign op      = s_data[31:28];

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        crst_d       = crst_q;
        run_d        = run_q;
        err_d        = err_q;
        rc_d         = (run_q && rc_q != '1) ? rc_q + 32'd1 : rc_q;
        insn_addr_d  = insn_addr_q;
        insn_din_d   = insn_din_q;
        data_addr_d  = data_addr_q;
        data_din_d   = data_din_q;
        insn_we_d    = 1'b0;
        data_we_d    = 1'b0;
        case (state_q)
            IDLE, RUNNING: if (acc) begin
                case (op)
                    4'd0: ;
                    4'd1, 4'd2: begin
                        state_d = ADDR;
                        tgt_d   = op == 4'd2;
                        cnt_d   = s_data[15:0];
                        run_d   = 1'b0;
                    end
                    4'd3: begin
                        state_d = CRST;
                        run_d   = 1'b0;
                        rc_d    = '0;
                        crst_d  = 32'(CORE_RST_CYCLES - 1);
                    end
                    4'd4: begin
                        state_d = IDLE;
                        run_d   = 1'b0;
                    end
                    4'd5: err_d = 1'b0;
                    default: err_d = 1'b1;
                endcase
            end
            ADDR: if (acc) begin
                addr_d  = s_data;
                state_d = (cnt_q == 16'd0) ? IDLE : PAYLOAD;
            end
            PAYLOAD: if (acc) begin
                insn_addr_d = tgt_q ? insn_addr_q : addr_q;
                insn_din_d  = tgt_q ? insn_din_q : s_data;
                insn_we_d   = !tgt_q;
                data_addr_d = tgt_q ? addr_q : data_addr_q;
                data_din_d  = tgt_q ? s_data : data_din_q;
                data_we_d   = tgt_q;
                addr_d      = addr_q + 32'(ADDR_STEP);
                cnt_d       = cnt_q - 16'd1;
                state_d     = (cnt_q == 16'd1) ? IDLE : PAYLOAD;
            end
            CRST: begin
                state_d = (crst_q == 32'd0) ? RUNNING : CRST;
                run_d   = crst_q == 32'd0;
                crst_d  = (crst_q == 32'd0) ? crst_q : crst_q - 32'd1;
            end
            default: state_d = IDLE;
        endcase
        busy_d       = state_d inside {ADDR, PAYLOAD, CRST};
        core_reset_d = state_d == CRST;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            tgt_q        <= 1'b0;
            cnt_q        <= '0;
            addr_q       <= '0;
            crst_q       <= '0;
            run_q        <= 1'b0;
            err_q        <= 1'b0;
            rc_q         <= '0;
            insn_addr_q  <= '0;
            insn_din_q   <= '0;
            data_addr_q  <= '0;
            data_din_q   <= '0;
            insn_we_q    <= 1'b0;
            data_we_q    <= 1'b0;
            busy_q       <= 1'b0;
            core_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            crst_q       <= crst_d;
            run_q        <= run_d;
            err_q        <= err_d;
            rc_q         <= rc_d;
            insn_addr_q  <= insn_addr_d;
            insn_din_q   <= insn_din_d;
            data_addr_q  <= data_addr_d;
            data_din_q   <= data_din_d;
            insn_we_q    <= insn_we_d;
            data_we_q    <= data_we_d;
            busy_q       <= busy_d;
            core_reset_q <= core_reset_d;
        end
    end

    assign insn_addr  = insn_addr_q;
    assign insn_din   = insn_din_q;
    assign insn_we    = insn_we_q;
    assign data_addr  = data_addr_q;
    assign data_din   = data_din_q;
    assign data_we    = data_we_q;
    assign core_reset = core_reset_q;
    assign run        = run_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign run_cycles = rc_q;
endmodule
